// File: rtl/branch_update_ctrl_if.sv
// Update bus from the branch-update controller into the PHT/BTB write port.
// The controller is the master; the predictor is the slave and returns upd_ready.
interface branch_update_ctrl_if #(
  parameter int IDX_W = 8
);
  logic             upd_valid;
  logic             upd_ready;
  logic             upd_init;
  logic [IDX_W-1:0] upd_index;
  logic             upd_taken;
  logic             upd_btb_we;
  logic [15:0]      upd_target;

  modport master (
    output upd_valid, upd_init, upd_index, upd_taken, upd_btb_we, upd_target,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, upd_init, upd_index, upd_taken, upd_btb_we, upd_target,
    output upd_ready
  );
endinterface

// File: rtl/branch_update_ctrl.sv
// Sequences PHT/BTB writes: post-reset init sweep, then a small FIFO of resolved
// branch outcomes drained one per cycle, plus registered mispredict/redirect.
module branch_update_ctrl #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     res_valid,
  input  logic [IDX_W-1:0]         res_index,
  input  logic                     res_taken,
  input  logic [15:0]              res_target,
  input  logic [15:0]              res_fallthrough,
  input  logic                     res_pred_taken,
  input  logic [15:0]              res_pred_target,
  branch_update_ctrl_if.master     upd,
  output logic                     mispredict,
  output logic [15:0]              redirect_pc,
  output logic                     pred_stall,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic [15:0]              br_count,
  output logic [15:0]              mp_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]       FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0]     LAST_IDX = '1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [0:0]       state;
  logic [IDX_W-1:0] init_idx;

  logic [IDX_W-1:0] q_idx [DEPTH];
  logic             q_tkn [DEPTH];
  logic [15:0]      q_tgt [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic             full;
  logic             accept_p0;
  logic             pop_p0;
  logic             mp_hit_p0;
  logic [15:0]      mp_pc_p0;
  logic             mp_p1;
  logic [15:0]      redir_p1;

  // Stage p0: accept decision and mispredict classification of the resolving branch
  assign full      = (count == FULL_CNT);
  assign accept_p0 = (state == ST_RUN) & res_valid & ~stall & ~full;
  assign pop_p0    = (state == ST_RUN) & (count != '0) & upd.upd_ready;
  assign mp_hit_p0 = res_taken ? (~res_pred_taken | (res_pred_target != res_target))
                               : res_pred_taken;
  assign mp_pc_p0  = res_taken ? res_target : res_fallthrough;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      init_idx <= '0;
    end else if (state == ST_INIT && upd.upd_ready) begin
      init_idx <= init_idx + 1'b1;
      if (init_idx == LAST_IDX) state <= ST_RUN;
    end
  end

  // Enqueue is gated by full alone, so a simultaneous pop never makes room early
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept_p0) wr_ptr <= wr_ptr + 1'b1;
      if (pop_p0)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept_p0, pop_p0})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept_p0) begin
      q_idx[wr_ptr] <= res_index;
      q_tkn[wr_ptr] <= res_taken;
      q_tgt[wr_ptr] <= res_target;
    end
  end

  // Stage p1: registered redirect pulse and statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mp_p1    <= 1'b0;
      redir_p1 <= '0;
      br_count <= '0;
      mp_count <= '0;
    end else begin
      mp_p1 <= accept_p0 & mp_hit_p0;
      if (accept_p0 & mp_hit_p0) begin
        redir_p1 <= mp_pc_p0;
        mp_count <= sat_inc(mp_count);
      end
      if (accept_p0) br_count <= sat_inc(br_count);
    end
  end

  always_comb begin
    upd.upd_valid  = 1'b1;
    upd.upd_init   = 1'b1;
    upd.upd_index  = init_idx;
    upd.upd_taken  = 1'b0;
    upd.upd_btb_we = 1'b1;
    upd.upd_target = '0;
    if (state == ST_RUN) begin
      upd.upd_valid  = (count != '0);
      upd.upd_init   = 1'b0;
      upd.upd_index  = q_idx[rd_ptr];
      upd.upd_taken  = q_tkn[rd_ptr];
      upd.upd_btb_we = q_tkn[rd_ptr];
      upd.upd_target = q_tgt[rd_ptr];
    end
  end

  assign mispredict  = mp_p1;
  assign redirect_pc = redir_p1;
  assign pred_stall  = (state == ST_INIT) | full;
  assign q_count     = count;

endmodule

// File: tb/tb_branch_update_ctrl.sv
// Directed-vector bench for branch_update_ctrl: init sweep, mispredict cases,
// FIFO fill/drain ordering, stall blocking and mid-operation reset.
module tb_branch_update_ctrl;
  localparam int DEPTH = 4;
  localparam int IDX_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             stall = 1'b0;
  logic             res_valid = 1'b0;
  logic [IDX_W-1:0] res_index = '0;
  logic             res_taken = 1'b0;
  logic [15:0]      res_target = '0;
  logic [15:0]      res_fallthrough = '0;
  logic             res_pred_taken = 1'b0;
  logic [15:0]      res_pred_target = '0;
  logic             mispredict;
  logic [15:0]      redirect_pc;
  logic             pred_stall;
  logic [2:0]       q_count;
  logic [15:0]      br_count;
  logic [15:0]      mp_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_update_ctrl_if #(.IDX_W(IDX_W)) upd ();

  branch_update_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .res_valid       (res_valid),
    .res_index       (res_index),
    .res_taken       (res_taken),
    .res_target      (res_target),
    .res_fallthrough (res_fallthrough),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .upd             (upd.master),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc),
    .pred_stall      (pred_stall),
    .q_count         (q_count),
    .br_count        (br_count),
    .mp_count        (mp_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic resolve(input logic [7:0] idx, input logic tk, input logic [15:0] tgt,
                         input logic [15:0] fall, input logic ptk, input logic [15:0] ptgt);
    res_valid       = 1'b1;
    res_index       = idx;
    res_taken       = tk;
    res_target      = tgt;
    res_fallthrough = fall;
    res_pred_taken  = ptk;
    res_pred_target = ptgt;
    step();
    res_valid = 1'b0;
  endtask

  task automatic init_sweep(input bit with_hold);
    for (int i = 0; i < 256; i++) begin
      chk("init_idx", 32'(upd.upd_index), i);
      chk("init_flag", 32'(upd.upd_init), 1);
      chk("init_stall", 32'(pred_stall), 1);
      if (with_hold && i == 10) begin
        upd.upd_ready = 1'b0;
        step();
        chk("init_hold", 32'(upd.upd_index), 10);
        upd.upd_ready = 1'b1;
      end
      step();
    end
    chk("run_stall", 32'(pred_stall), 0);
    chk("run_valid", 32'(upd.upd_valid), 0);
    chk("run_init", 32'(upd.upd_init), 0);
    chk("run_q", 32'(q_count), 0);
  endtask

  initial begin
    upd.upd_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(upd.upd_valid), 1);
    chk("rst_init", 32'(upd.upd_init), 1);
    chk("rst_index", 32'(upd.upd_index), 0);
    chk("rst_taken", 32'(upd.upd_taken), 0);
    chk("rst_btb_we", 32'(upd.upd_btb_we), 1);
    chk("rst_target", 32'(upd.upd_target), 0);
    chk("rst_mp", 32'(mispredict), 0);
    chk("rst_redir", 32'(redirect_pc), 0);
    chk("rst_stall", 32'(pred_stall), 1);
    chk("rst_q", 32'(q_count), 0);
    chk("rst_br", 32'(br_count), 0);
    chk("rst_mpc", 32'(mp_count), 0);
    rst = 1'b0;

    init_sweep(1'b1);

    // Taken, predicted not-taken
    resolve(8'h3C, 1'b1, 16'h1234, 16'h0100, 1'b0, 16'h0000);
    chk("mp1_pulse", 32'(mispredict), 1);
    chk("mp1_redir", 32'(redirect_pc), 'h1234);
    chk("mp1_valid", 32'(upd.upd_valid), 1);
    chk("mp1_index", 32'(upd.upd_index), 'h3C);
    chk("mp1_btb_we", 32'(upd.upd_btb_we), 1);
    chk("mp1_taken", 32'(upd.upd_taken), 1);
    chk("mp1_target", 32'(upd.upd_target), 'h1234);
    chk("mp1_mpc", 32'(mp_count), 1);
    chk("mp1_br", 32'(br_count), 1);
    step();
    chk("mp1_pulse_end", 32'(mispredict), 0);
    chk("mp1_drained", 32'(q_count), 0);
    chk("mp1_valid_end", 32'(upd.upd_valid), 0);

    // Not taken, predicted taken
    resolve(8'h55, 1'b0, 16'h0300, 16'h0202, 1'b1, 16'h0300);
    chk("mp2_pulse", 32'(mispredict), 1);
    chk("mp2_redir", 32'(redirect_pc), 'h0202);
    chk("mp2_index", 32'(upd.upd_index), 'h55);
    chk("mp2_taken", 32'(upd.upd_taken), 0);
    chk("mp2_btb_we", 32'(upd.upd_btb_we), 0);
    chk("mp2_mpc", 32'(mp_count), 2);
    step();

    // Correct taken prediction with matching target
    resolve(8'h11, 1'b1, 16'h4444, 16'h0010, 1'b1, 16'h4444);
    chk("ok_t_pulse", 32'(mispredict), 0);
    chk("ok_t_br", 32'(br_count), 3);
    chk("ok_t_mpc", 32'(mp_count), 2);
    step();

    // Correct not-taken prediction
    resolve(8'h12, 1'b0, 16'h4000, 16'h0012, 1'b0, 16'h0000);
    chk("ok_n_pulse", 32'(mispredict), 0);
    chk("ok_n_btb_we", 32'(upd.upd_btb_we), 0);
    chk("ok_n_br", 32'(br_count), 4);
    step();

    // Taken and predicted taken, wrong BTB target
    resolve(8'h22, 1'b1, 16'h5002, 16'h0022, 1'b1, 16'h5000);
    chk("tgt_pulse", 32'(mispredict), 1);
    chk("tgt_redir", 32'(redirect_pc), 'h5002);
    chk("tgt_mpc", 32'(mp_count), 3);
    chk("tgt_br", 32'(br_count), 5);
    step();

    // Stall blocks acceptance entirely
    stall = 1'b1;
    resolve(8'h33, 1'b1, 16'h6000, 16'h0033, 1'b0, 16'h0000);
    stall = 1'b0;
    chk("stall_pulse", 32'(mispredict), 0);
    chk("stall_br", 32'(br_count), 5);
    chk("stall_q", 32'(q_count), 0);

    // Fill with predictor back-pressured: fifth attempt is refused
    upd.upd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      resolve(8'(8'hA0 + i), i[0], 16'(16'h1000 + i), 16'h0000, i[0], 16'(16'h1000 + i));
      if (i < 4) chk("fill_q", 32'(q_count), i + 1);
    end
    chk("full_q", 32'(q_count), 4);
    chk("full_stall", 32'(pred_stall), 1);
    chk("full_br", 32'(br_count), 9);
    chk("full_head", 32'(upd.upd_index), 'hA0);
    upd.upd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_index", 32'(upd.upd_index), 'hA0 + i);
      chk("drain_taken", 32'(upd.upd_taken), i & 1);
      chk("drain_target", 32'(upd.upd_target), 'h1000 + i);
      step();
    end
    chk("drain_q", 32'(q_count), 0);
    chk("drain_valid", 32'(upd.upd_valid), 0);

    // Simultaneous enqueue and dequeue keep occupancy
    upd.upd_ready = 1'b0;
    resolve(8'hB0, 1'b0, 16'h0000, 16'h00B0, 1'b0, 16'h0000);
    chk("sim_q1", 32'(q_count), 1);
    upd.upd_ready = 1'b1;
    resolve(8'hB1, 1'b0, 16'h0000, 16'h00B1, 1'b0, 16'h0000);
    chk("sim_q_same", 32'(q_count), 1);
    chk("sim_head", 32'(upd.upd_index), 'hB1);
    step();
    chk("sim_q0", 32'(q_count), 0);
    chk("sim_br", 32'(br_count), 11);

    // Reset with entries pending and a mispredict pulse in flight
    upd.upd_ready = 1'b0;
    resolve(8'hC0, 1'b0, 16'h0000, 16'h00C0, 1'b0, 16'h0000);
    resolve(8'hC1, 1'b0, 16'h0000, 16'h00C1, 1'b0, 16'h0000);
    resolve(8'hC2, 1'b1, 16'h7777, 16'h00C2, 1'b0, 16'h0000);
    chk("pre_rst_q", 32'(q_count), 3);
    chk("pre_rst_pulse", 32'(mispredict), 1);
    chk("pre_rst_mpc", 32'(mp_count), 4);
    rst = 1'b1;
    #1;
    chk("arst_q", 32'(q_count), 0);
    chk("arst_pulse", 32'(mispredict), 0);
    chk("arst_redir", 32'(redirect_pc), 0);
    chk("arst_br", 32'(br_count), 0);
    chk("arst_mpc", 32'(mp_count), 0);
    chk("arst_init", 32'(upd.upd_init), 1);
    chk("arst_index", 32'(upd.upd_index), 0);
    chk("arst_stall", 32'(pred_stall), 1);
    step();
    chk("rst_hold_pulse", 32'(mispredict), 0);
    upd.upd_ready = 1'b1;
    rst = 1'b0;
    init_sweep(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/branch_update_ctrl.md
# branch_update_ctrl

Controller that sequences all writes into the branch predictor's pattern history table (PHT) and branch target buffer (BTB). It sits between the EX/MEM stage and the predictor. It detects mispredictions and issues the redirect/flush, and buffers resolved outcomes in a small FIFO so the predictor receives at most one update per cycle under a ready handshake. After reset it performs an initialisation sweep over all 256 predictor entries before the pipeline is released.

## Interface
- DEPTH, 4, update FIFO entries (power of two, ≥2)
- IDX_W, 8, predictor index width (PHT/BTB have 2^IDX_W entries)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  pipeline stall; resolution not accepted while high
- res_valid  in  1  EX/MEM holds a resolved br/jmp/jsr/trap
- res_index  in  IDX_W  predictor index captured at fetch (pc xor history)
- res_taken  in  1  actual outcome
- res_target  in  16  actual target address
- res_fallthrough  in  16  pc+2 of the control instruction
- res_pred_taken  in  1  prediction made at fetch
- res_pred_target  in  16  BTB target used at fetch
- upd_ready  in  1  predictor accepts the presented update this cycle
- upd_valid  out  1  update presented
- upd_init  out  1  update is an init write (PHT←2'b01, BTB←0)
- upd_index  out  IDX_W  entry to write
- upd_taken  out  1  increment (1) / decrement (0) saturating PHT counter
- upd_btb_we  out  1  write upd_target into BTB
- upd_target  out  16  BTB write data
- mispredict  out  1  one-cycle pulse: flush IF/ID/EX, redirect fetch
- redirect_pc  out  16  fetch address valid when mispredict=1
- pred_stall  out  1  hold the pipeline (init running or FIFO full)
- q_count  out  $clog2(DEPTH)+1  FIFO occupancy
- br_count  out  16  resolved control instructions, saturating
- mp_count  out  16  mispredictions, saturating

## Operation
- States: INIT, RUN. rst forces INIT with idx counter = 0.
- INIT: upd_valid=1, upd_init=1, upd_index=counter, upd_btb_we=1, upd_target=0, upd_taken=0. Counter advances on upd_ready. When the final entry (2^IDX_W−1) is accepted, transition to RUN. pred_stall=1 throughout INIT.
- Accept: in RUN when res_valid & !stall & !full. An accepted resolution enqueues {res_index, res_taken, res_target}. Enqueue is blocked whenever full, even if a dequeue occurs in the same cycle.
- Dequeue (RUN): when not empty, the head drives upd_*. upd_init=0, upd_btb_we=head.taken. The entry pops on upd_ready. Enqueue and dequeue in the same cycle leave q_count unchanged.
- Mispredict on accept:
  - taken & (!pred_taken | pred_target≠target) → redirect_pc=res_target.
  - !taken & pred_taken → redirect_pc=res_fallthrough.
  - Otherwise no pulse.
- br_count increments on every accept. mp_count increments on every mispredict. Both saturate at 16'hFFFF.
- pred_stall = (state==INIT) | full.

## Timing
- Reset values: upd_valid=1 and upd_init=1 (INIT entered), upd_index=0, upd_taken=0, upd_btb_we=1, upd_target=0, mispredict=0, redirect_pc=0, pred_stall=1, q_count=0, br_count=0, mp_count=0.
- mispredict/redirect_pc are registered. The pulse is high for exactly the cycle after the accepting edge.
- Enqueue-to-upd_valid latency: 1 cycle when the FIFO was empty. No combinational path from res_* to upd_*.
- upd_* are stable while upd_valid=1 and upd_ready=0.
- INIT lasts 2^IDX_W cycles with upd_ready held high. Each low cycle of upd_ready extends INIT by one cycle.
- Pointers wrap modulo DEPTH; full means q_count==DEPTH.
- rst mid-operation: FIFO contents are discarded, counters clear, and INIT restarts from index 0. No mispredict pulse is generated.
- stall=1 with res_valid=1: no accept, no count, no pulse. Dequeue continues.

## Test plan
- Reset, upd_ready=1 → INIT for 256 cycles with indices 0..255 in order, upd_init=1, then pred_stall falls to 0 on cycle 257.
- RUN, accept {idx=8'h3C, taken=1, target=16'h1234, pred_taken=0} → mispredict one cycle later with redirect_pc=16'h1234. Next cycle: upd_index=8'h3C, upd_btb_we=1. mp_count=1.
- pred_taken=1, taken=0, fallthrough=16'h0202 → redirect_pc=16'h0202. Update has upd_taken=0 and upd_btb_we=0.
- upd_ready=0 with 5 consecutive accepts attempted → 4 enqueued, pred_stall=1, q_count=4. Raising upd_ready drains the entries in FIFO order, one per cycle.
- Correct prediction (taken, matching target) → no mispredict. br_count increments and mp_count does not.
- Assert rst with q_count=3 → q_count=0, INIT restarts at index 0, and no stale updates are emitted.
